mem_seq: RTL and testbench

Memory access sequencer sitting directly downstream of the address register. It takes the 16-bit address held by AR and the write data from the bus. It runs one read or write cycle on the asynchronous main-memory SRAM with a programmable number of wait states. On a read it returns the data in a holding register for the bus. The controller issues level requests and waits for `done`; `busy` lets it stall microsteps.

---
 rtl/mem_seq.sv | 153 +++++++++++++++
 tb/tb_mem_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// Memory access sequencer: one read or write cycle on an asynchronous SRAM
// with programmable wait states. Optional address range rejection: MEMSEQ_RANGE_CHECK_EN.
module mem_seq #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] MEM_TOP     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

`ifdef MEMSEQ_RANGE_CHECK_EN
  localparam logic RangeCheck = 1'b1;
`else
  localparam logic RangeCheck = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        isRead_q, isRead_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] memAddr_q, memAddr_d;
  logic [15:0] memWdata_q, memWdata_d;
  logic        ceN_q, ceN_d;
  logic        oeN_q, oeN_d;
  logic        weN_q, weN_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rangeBad;

  assign rangeBad = RangeCheck && (addr > MEM_TOP);

  // Strobes are computed one state ahead so every SRAM control is a flop output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    isRead_d   = isRead_q;
    rdata_d    = rdata_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ceN_d      = ceN_q;
    oeN_d      = oeN_q;
    weN_d      = weN_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd ^ wr) begin
          if (rangeBad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            memAddr_d  = addr;
            memWdata_d = wdata;
            isRead_d   = rd;
            ceN_d      = 1'b0;
            state_d    = ST_SETUP;
          end
        end else if (rd && wr) begin
          err_d = 1'b1;
        end
      end
      ST_SETUP: begin
        cnt_d   = WaitLoad;
        oeN_d   = ~isRead_q;
        weN_d   = isRead_q;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (isRead_q) begin
            rdata_d = mem_rdata;
          end
          ceN_d   = 1'b1;
          oeN_d   = 1'b1;
          weN_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        ceN_d   = 1'b1;
        oeN_d   = 1'b1;
        weN_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      isRead_q   <= 1'b0;
      rdata_q    <= 16'h0000;
      memAddr_q  <= 16'h0000;
      memWdata_q <= 16'h0000;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      isRead_q   <= isRead_d;
      rdata_q    <= rdata_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ceN_q      <= ceN_d;
      oeN_q      <= oeN_d;
      weN_q      <= weN_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_ce_n  = ceN_q;
  assign mem_oe_n  = oeN_q;
  assign mem_we_n  = weN_q;

endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: three instances (0, 2 and 4 wait states) each on its own
// SRAM model; table-driven accesses with a read-data scoreboard plus corner sequences.
module tb_mem_seq;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr, wdata;
  logic [N-1:0] rd, wr, busy, done, err, ceN, oeN, weN;
  logic [15:0] rdata [N];
  logic [15:0] memAddr [N];
  logic [15:0] memWdata [N];
  logic [15:0] memRdata [N];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : gInst
      logic [15:0] sram [256];
      logic        loaded = 1'b0;

      mem_seq #(.WAIT_CYCLES(2 * g), .MEM_TOP(16'h7FFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .rd        (rd[g]),
        .wr        (wr[g]),
        .rdata     (rdata[g]),
        .busy      (busy[g]),
        .done      (done[g]),
        .err       (err[g]),
        .mem_addr  (memAddr[g]),
        .mem_wdata (memWdata[g]),
        .mem_rdata (memRdata[g]),
        .mem_ce_n  (ceN[g]),
        .mem_oe_n  (oeN[g]),
        .mem_we_n  (weN[g])
      );

      assign memRdata[g] = (!ceN[g] && !oeN[g]) ? sram[memAddr[g][7:0]] : 16'hDEAD;

      // Contents preload on the first clock: {A5, low address byte}, with BEEF at 0x40.
      always @(posedge clk) begin
        if (!loaded) begin
          for (int i = 0; i < 256; i++) sram[i] <= {8'hA5, 8'(i)};
          sram[8'h40] <= 16'hBEEF;
          loaded <= 1'b1;
        end else if (!ceN[g] && !weN[g]) begin
          sram[memAddr[g][7:0]] <= memWdata[g];
        end
      end
    end
  endgenerate

  typedef struct {
    int          inst;
    logic        rdReq;
    logic        wrReq;
    logic [15:0] a;
    logic [15:0] d;
    logic        expErr;
    logic        acc;
    logic [15:0] expRdata;
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [15:0] sb [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int inst, input logic r, input logic w,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic e, input logic acc, input logic [15:0] x);
    vec_t v;
    v.inst = inst; v.rdReq = r; v.wrReq = w; v.a = a; v.d = d;
    v.expErr = e; v.acc = acc; v.expRdata = x;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input int n);
    int i, w, doneAt, doneCnt, errCnt, ceCnt, oeCnt, weCnt, addrBad, busyBad, expDoneAt;
    logic [15:0] exp;
    i = v.inst; w = 2 * i;
    doneAt = 0; doneCnt = 0; errCnt = 0; ceCnt = 0; oeCnt = 0; weCnt = 0;
    addrBad = 0; busyBad = 0;
    @(negedge clk);
    addr = v.a; wdata = v.d; rd[i] = v.rdReq; wr[i] = v.wrReq;
    sb.push_back(v.expRdata);
    for (int k = 1; k <= w + 6; k++) begin
      @(negedge clk);
      if (!ceN[i]) ceCnt++;
      if (!oeN[i]) oeCnt++;
      if (!weN[i]) weCnt++;
      if ((!oeN[i] || !weN[i]) && (memAddr[i] != v.a || (v.wrReq && memWdata[i] != v.d))) addrBad++;
      if (err[i]) begin
        errCnt++;
        if (busy[i]) busyBad++;
      end
      if (done[i]) begin
        doneCnt++;
        if (doneAt == 0) doneAt = k;
      end
      if ((done[i] || err[i]) && sb.size() > 0) begin
        exp = sb.pop_front();
        checkOutput($sformatf("v%0d rdata", n), rdata[i], exp);
      end
      if (done[i] || err[i]) begin
        rd[i] = 1'b0; wr[i] = 1'b0;
      end
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
    expDoneAt = v.acc ? w + 3 : ((v.expErr && !(v.rdReq && v.wrReq)) ? 1 : 0);
    checkOutput($sformatf("v%0d scoreboardEmpty", n), sb.size(), 0);
    sb.delete();
    checkOutput($sformatf("v%0d doneCycle", n), doneAt, expDoneAt);
    checkOutput($sformatf("v%0d doneCount", n), doneCnt, (expDoneAt != 0) ? 1 : 0);
    checkOutput($sformatf("v%0d errCount", n), errCnt, v.expErr ? 1 : 0);
    checkOutput($sformatf("v%0d busyDuringErr", n), busyBad, 0);
    checkOutput($sformatf("v%0d ceLowClocks", n), ceCnt, v.acc ? w + 2 : 0);
    checkOutput($sformatf("v%0d oeLowClocks", n), oeCnt, (v.acc && v.rdReq) ? w + 1 : 0);
    checkOutput($sformatf("v%0d weLowClocks", n), weCnt, (v.acc && v.wrReq) ? w + 1 : 0);
    checkOutput($sformatf("v%0d addrDataStable", n), addrBad, 0);
  endtask

  vec_t vecs [9];

  initial begin
    int ceCnt, errCnt, doneCnt;
    vecs[0] = mk(1, 1, 0, 16'h0040, 16'h0000, 0, 1, 16'hBEEF);
    vecs[1] = mk(0, 0, 1, 16'h1234, 16'h5A5A, 0, 1, 16'h0000);
    vecs[2] = mk(0, 1, 0, 16'h1234, 16'h0000, 0, 1, 16'h5A5A);
    vecs[3] = mk(2, 0, 1, 16'h0055, 16'h1111, 0, 1, 16'h0000);
    vecs[4] = mk(2, 1, 0, 16'h0055, 16'h0000, 0, 1, 16'h1111);
    vecs[5] = mk(1, 1, 1, 16'h0040, 16'h0000, 1, 0, 16'hBEEF);
    vecs[6] = mk(1, 1, 0, 16'h0041, 16'h0000, 0, 1, 16'hA541);
`ifdef MEMSEQ_RANGE_CHECK_EN
    vecs[7] = mk(2, 1, 0, 16'h8000, 16'h0000, 1, 0, 16'h1111);
`else
    vecs[7] = mk(2, 1, 0, 16'h8000, 16'h0000, 0, 1, 16'hA500);
`endif
    vecs[8] = mk(2, 1, 0, 16'h7FFF, 16'h0000, 0, 1, 16'hA5FF);

    rst = 1'b0; rd = '0; wr = '0; addr = 16'h0000; wdata = 16'h0000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("reset data i%0d", i), {rdata[i] | memAddr[i] | memWdata[i]}, 32'h0);
      checkOutput($sformatf("reset ctrl i%0d", i),
                  {busy[i], done[i], err[i], ceN[i], oeN[i], weN[i]}, 32'b000111);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 9; n++) applyStimulus(vecs[n], n);

    // Requests raised while busy (and an address change) must not affect the access.
    @(negedge clk);
    addr = 16'h0040; rd[1] = 1'b1;
    ceCnt = 0; errCnt = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        wr[1] = 1'b1; addr = 16'h0041;
      end
      if (!ceN[1]) ceCnt++;
      if (err[1]) errCnt++;
      if (done[1]) begin
        checkOutput("busyIgnore rdata", rdata[1], 16'hBEEF);
        rd[1] = 1'b0; wr[1] = 1'b0;
      end
    end
    rd[1] = 1'b0; wr[1] = 1'b0;
    checkOutput("busyIgnore ceLowClocks", ceCnt, 4);
    checkOutput("busyIgnore errCount", errCnt, 0);
    checkOutput("busyIgnore memAddr", memAddr[1], 16'h0040);

    // Reset asserted in the third ACCESS clock of a 4-wait-state write.
    @(negedge clk);
    addr = 16'h0077; wdata = 16'h7777; wr[2] = 1'b1;
    doneCnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done[2]) doneCnt++;
    end
    checkOutput("midReset weLowBefore", weN[2], 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("midReset strobes", {ceN[2], oeN[2], weN[2]}, 3'b111);
    checkOutput("midReset busy", busy[2], 1'b0);
    checkOutput("midReset rdata", rdata[2], 16'h0000);
    wr[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b1;
      if (done[2]) doneCnt++;
    end
    checkOutput("midReset doneCount", doneCnt, 0);
    checkOutput("midReset idle", {busy[2], ceN[2]}, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
